// File: rtl/renas_l2_refill_master_if.sv
// Request/response and memory-bus bundle for the L2 refill master.
// master modport is the refill engine side; slave modport is the cache/memory side.
interface renas_l2_refill_master_if #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_WORDS = 4
);
    localparam int unsigned LINE_W = WORD_W * LINE_WORDS;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wb;
    logic [ADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0] wb_data;
    logic              resp_valid;
    logic [LINE_W-1:0] resp_data;
    logic              resp_err;

    logic              mem_hsel;
    logic [ADDR_W-1:0] mem_haddr;
    logic              mem_hwrite;
    logic [WORD_W-1:0] mem_hwdata;
    logic [1:0]        mem_htrans;
    logic [2:0]        mem_hsize;
    logic              mem_hreadyout;
    logic [WORD_W-1:0] mem_hrdata;
    logic              mem_hresp;

    modport master (
        input  req_valid, req_addr, req_wb, wb_addr, wb_data,
               mem_hreadyout, mem_hrdata, mem_hresp,
        output req_ready, resp_valid, resp_data, resp_err,
               mem_hsel, mem_haddr, mem_hwrite, mem_hwdata, mem_htrans, mem_hsize
    );

    modport slave (
        output req_valid, req_addr, req_wb, wb_addr, wb_data,
               mem_hreadyout, mem_hrdata, mem_hresp,
        input  req_ready, resp_valid, resp_data, resp_err,
               mem_hsel, mem_haddr, mem_hwrite, mem_hwdata, mem_htrans, mem_hsize
    );
endinterface

// File: rtl/renas_l2_refill_master.sv
// L2 line-miss engine: optional victim writeback, then word-by-word refill over hsel/hreadyout.
// Define RENAS_REFILL_CWF_EN to refill critical word first (wrapping); default refills from word 0.
module renas_l2_refill_master #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                             clk_l2,
    input  logic                             rst,
    renas_l2_refill_master_if.master         bus
);
    localparam int unsigned IDX_W    = $clog2(LINE_WORDS);
    localparam int unsigned LINE_W   = WORD_W * LINE_WORDS;
    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned BASE_LSB = IDX_W + 2;
    localparam int unsigned BASE_W   = ADDR_W - BASE_LSB;

    typedef enum logic [2:0] {IDLE, WB_REQ, WB_GAP, RF_REQ, RF_GAP, DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [BASE_W-1:0]   rf_base_q, rf_base_d;
    logic [IDX_W-1:0]    rf_start_q, rf_start_d;
    logic [BASE_W-1:0]   wb_base_q, wb_base_d;
    logic [LINE_W-1:0]   wb_data_q, wb_data_d;
    logic [LINE_W-1:0]   buf_q, buf_d;
    logic                err_q, err_d;

    logic                req_ready_q, resp_valid_q, resp_err_q;
    logic                hsel_q, hwrite_q;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic [WORD_W-1:0]   hwdata_q, hwdata_d;

    logic [IDX_W-1:0]    req_start;
    logic                unused_addr_bits;

`ifdef RENAS_REFILL_CWF_EN
    assign req_start = bus.req_addr[BASE_LSB-1:2];
`else
    assign req_start = '0;
`endif
    assign unused_addr_bits = ^{bus.req_addr[BASE_LSB-1:0], bus.wb_addr[BASE_LSB-1:0]};

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        rf_base_d  = rf_base_q;
        rf_start_d = rf_start_q;
        wb_base_d  = wb_base_q;
        wb_data_d  = wb_data_q;
        buf_d      = buf_q;
        err_d      = err_q;
        haddr_d    = '0;
        hwdata_d   = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    rf_base_d  = bus.req_addr[ADDR_W-1:BASE_LSB];
                    rf_start_d = req_start;
                    wb_base_d  = bus.wb_addr[ADDR_W-1:BASE_LSB];
                    wb_data_d  = bus.wb_data;
                    buf_d      = '0;
                    err_d      = 1'b0;
                    cnt_d      = '0;
                    tmo_d      = '0;
                    if (bus.req_wb) begin
                        state_d = WB_REQ;
                        idx_d   = '0;
                    end else begin
                        state_d = RF_REQ;
                        idx_d   = req_start;
                    end
                end
            end
            WB_REQ, RF_REQ: begin
                if (bus.mem_hreadyout) begin
                    if (bus.mem_hresp) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (state_q == RF_REQ) begin
                        buf_d[32'(idx_q)*WORD_W +: WORD_W] = bus.mem_hrdata;
                        state_d = RF_GAP;
                    end else begin
                        state_d = WB_GAP;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WB_GAP: begin
                tmo_d = '0;
                if (cnt_q == IDX_W'(LINE_WORDS - 1)) begin
                    cnt_d   = '0;
                    idx_d   = rf_start_q;
                    state_d = RF_REQ;
                end else begin
                    cnt_d   = cnt_q + IDX_W'(1);
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = WB_REQ;
                end
            end
            RF_GAP: begin
                tmo_d = '0;
                if (cnt_q == IDX_W'(LINE_WORDS - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + IDX_W'(1);
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = RF_REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus fields are decoded from next state so they are registered in step with hsel.
        if (state_d == WB_REQ) begin
            haddr_d  = {wb_base_d, idx_d, 2'b00};
            hwdata_d = wb_data_d[32'(idx_d)*WORD_W +: WORD_W];
        end else if (state_d == RF_REQ) begin
            haddr_d  = {rf_base_d, idx_d, 2'b00};
        end
    end

    always_ff @(posedge clk_l2) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            rf_base_q    <= '0;
            rf_start_q   <= '0;
            wb_base_q    <= '0;
            wb_data_q    <= '0;
            buf_q        <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            hsel_q       <= 1'b0;
            hwrite_q     <= 1'b0;
            haddr_q      <= '0;
            hwdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            rf_base_q    <= rf_base_d;
            rf_start_q   <= rf_start_d;
            wb_base_q    <= wb_base_d;
            wb_data_q    <= wb_data_d;
            buf_q        <= buf_d;
            err_q        <= err_d;
            req_ready_q  <= (state_d == IDLE);
            resp_valid_q <= (state_d == DONE);
            resp_err_q   <= (state_d == DONE) && err_d;
            hsel_q       <= (state_d == WB_REQ) || (state_d == RF_REQ);
            hwrite_q     <= (state_d == WB_REQ);
            haddr_q      <= haddr_d;
            hwdata_q     <= hwdata_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = buf_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_hsel   = hsel_q;
    assign bus.mem_haddr  = haddr_q;
    assign bus.mem_hwrite = hwrite_q;
    assign bus.mem_hwdata = hwdata_q;
    assign bus.mem_htrans = {hsel_q, 1'b0};
    assign bus.mem_hsize  = 3'b010;
endmodule

// File: tb/tb_renas_l2_refill_master.sv
// Scoreboard bench for renas_l2_refill_master: randomized line requests, scripted slave behaviour,
// and a line-level reference model predicting bus operations and responses.
module tb_renas_l2_refill_master;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned TIMEOUT    = 8;
    localparam int unsigned LINE_W     = WORD_W * LINE_WORDS;
    localparam int unsigned LINE_BYTES = LINE_WORDS * 4;

    typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] data; } op_t;
    typedef struct packed { logic [LINE_W-1:0] data; logic err; } resp_t;
    // kind: 0 ok, 1 hresp error, 2 never ready (length checked), 3 never ready (cut by reset)
    typedef struct packed { logic [1:0] kind; logic [3:0] lat; } act_t;

    logic clk_l2 = 1'b0;
    logic rst    = 1'b1;
    always #5 clk_l2 = ~clk_l2;

    renas_l2_refill_master_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS)) bus();

    renas_l2_refill_master #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_l2(clk_l2),
        .rst(rst),
        .bus(bus)
    );

    op_t   exp_op_q[$];
    resp_t exp_resp_q[$];
    act_t  plan_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [LINE_W:0] act, input logic [LINE_W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1) begin
            @(posedge clk_l2); #1;
            n++;
            if (n > 500) begin
                n_cmp++; n_bad++;
                $display("FAIL wait_ready: req_ready=%b after %0d cycles, required 1", bus.req_ready, n);
                summary();
                $finish;
            end
        end
    endtask

    // Reference model: line-level expectation of bus ops, slave script and response.
    task automatic issue(input logic [31:0] ra, input logic wb, input logic [31:0] wa,
                         input logic [LINE_W-1:0] wd, input int abort_at, input logic [1:0] abort_kind,
                         input int fixed_lat, input bit expect_resp);
        op_t ops[$];
        op_t o;
        act_t a;
        resp_t r;
        int start;
        int w;
        logic [31:0] rbase;
        logic [31:0] wbase;
        rbase = ra & ~(LINE_BYTES - 1);
        wbase = wa & ~(LINE_BYTES - 1);
`ifdef RENAS_REFILL_CWF_EN
        start = int'((ra % LINE_BYTES) / 4);
`else
        start = 0;
`endif
        if (wb) begin
            for (int i = 0; i < int'(LINE_WORDS); i++) begin
                o.wr = 1'b1; o.addr = wbase + 32'(4 * i); o.data = wd[i*WORD_W +: WORD_W];
                ops.push_back(o);
            end
        end
        for (int k = 0; k < int'(LINE_WORDS); k++) begin
            w = (start + k) % int'(LINE_WORDS);
            o.wr = 1'b0; o.addr = rbase + 32'(4 * w); o.data = '0;
            ops.push_back(o);
        end
        r.data = '0;
        r.err  = 1'b0;
        for (int j = 0; j < ops.size(); j++) begin
            exp_op_q.push_back(ops[j]);
            a.lat = (fixed_lat >= 0) ? 4'(fixed_lat) : 4'($urandom_range(0, 4));
            if (j == abort_at) begin
                a.kind = abort_kind;
                plan_q.push_back(a);
                r.err = 1'b1;
                break;
            end
            a.kind = 2'd0;
            plan_q.push_back(a);
            if (!ops[j].wr) begin
                w = int'((ops[j].addr % LINE_BYTES) / 4);
                r.data[w*WORD_W +: WORD_W] = rd_word(ops[j].addr);
            end
        end
        if (expect_resp) exp_resp_q.push_back(r);
        wait_ready();
        bus.req_addr  = ra;
        bus.req_wb    = wb;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        bus.req_valid = 1'b1;
        @(posedge clk_l2); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wb    = 1'($urandom);
    endtask

    // Memory slave following the scripted per-word plan; stray hreadyout pulses while hsel is low.
    initial begin
        act_t a;
        logic [31:0] ad;
        int n;
        bus.mem_hreadyout = 1'b0;
        bus.mem_hresp     = 1'b0;
        bus.mem_hrdata    = '0;
        forever begin
            @(posedge clk_l2); #1;
            bus.mem_hreadyout = 1'b0;
            bus.mem_hresp     = 1'b0;
            if (bus.mem_hsel === 1'b1 && !rst) begin
                if (plan_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL slave_plan: request at %h with no scripted word", bus.mem_haddr);
                end else begin
                    a  = plan_q.pop_front();
                    ad = bus.mem_haddr;
                    if (a.kind >= 2'd2) begin
                        n = 1;
                        while (bus.mem_hsel === 1'b1 && n <= int'(TIMEOUT) + 4) begin
                            @(posedge clk_l2); #1;
                            if (bus.mem_hsel === 1'b1) n++;
                        end
                        if (a.kind == 2'd2) chk("timeout_len", (LINE_W+1)'(n), (LINE_W+1)'(TIMEOUT));
                    end else begin
                        repeat (int'(a.lat)) begin @(posedge clk_l2); #1; end
                        bus.mem_hreadyout = 1'b1;
                        bus.mem_hresp     = a.kind[0];
                        bus.mem_hrdata    = a.kind[0] ? 32'($urandom) : rd_word(ad);
                    end
                end
            end else if ($urandom_range(0, 5) == 0) begin
                bus.mem_hreadyout = 1'b1;
                bus.mem_hresp     = 1'($urandom);
                bus.mem_hrdata    = $urandom;
            end
        end
    end

    // Monitor: pops expected ops on each new hsel and expected responses on resp_valid.
    initial begin
        logic prev_hsel;
        logic [64:0] held;
        int gap;
        int words;
        bit ready_next;
        op_t got;
        op_t e;
        resp_t er;
        prev_hsel = 1'b0; held = '0; gap = 0; words = 0; ready_next = 0;
        forever begin
            @(negedge clk_l2);
            if (rst) begin
                prev_hsel = 1'b0; gap = 0; words = 0; ready_next = 0;
                continue;
            end
            if (ready_next) begin
                chk("ready_after_resp", (LINE_W+1)'(bus.req_ready), (LINE_W+1)'(1));
                chk("resp_one_cycle", (LINE_W+1)'(bus.resp_valid), (LINE_W+1)'(0));
                ready_next = 0;
            end
            got.wr   = bus.mem_hwrite;
            got.addr = bus.mem_haddr;
            got.data = bus.mem_hwrite ? bus.mem_hwdata : 32'h0;
            if (bus.mem_hsel && !prev_hsel) begin
                if (words > 0) chk("gap_len", (LINE_W+1)'(gap), (LINE_W+1)'(1));
                if (exp_op_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_op: got %h with nothing expected", got);
                end else begin
                    e = exp_op_q.pop_front();
                    chk("mem_op", (LINE_W+1)'(got), (LINE_W+1)'(e));
                end
                chk("htrans", (LINE_W+1)'(bus.mem_htrans), (LINE_W+1)'(2'b10));
                chk("hsize", (LINE_W+1)'(bus.mem_hsize), (LINE_W+1)'(3'b010));
                held = got;
            end else if (bus.mem_hsel && prev_hsel) begin
                chk("op_hold", (LINE_W+1)'(got), (LINE_W+1)'(held));
            end
            if (!bus.mem_hsel) begin
                if (prev_hsel) begin words++; gap = 1; end
                else gap++;
            end
            if (bus.resp_valid) begin
                if (exp_resp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_resp: got data %h err %b", bus.resp_data, bus.resp_err);
                end else begin
                    er = exp_resp_q.pop_front();
                    chk("resp_data", (LINE_W+1)'(bus.resp_data), (LINE_W+1)'(er.data));
                    chk("resp_err", (LINE_W+1)'(bus.resp_err), (LINE_W+1)'(er.err));
                end
                words = 0;
                ready_next = 1;
            end
            prev_hsel = bus.mem_hsel;
        end
    end

    initial begin
        #500000;
        n_cmp++; n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
        $finish;
    end

    initial begin
        logic [LINE_W-1:0] wd;
        int total;
        int r;
        int n;
        bit wb;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wb    = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        repeat (3) @(posedge clk_l2);
        #1;
        chk("rst_req_ready", (LINE_W+1)'(bus.req_ready), (LINE_W+1)'(1));
        chk("rst_bus", (LINE_W+1)'({bus.mem_hsel, bus.mem_hwrite, bus.mem_htrans, bus.mem_haddr, bus.mem_hwdata}), '0);
        chk("rst_resp", (LINE_W+1)'({bus.resp_valid, bus.resp_err}), '0);
        chk("rst_resp_data", (LINE_W+1)'(bus.resp_data), '0);
        rst = 1'b0;
        @(posedge clk_l2); #1;

        // Directed cases.
        issue(32'h0000_2008, 1'b0, 32'h0, '0, -1, 2'd0, 2, 1'b1);
        issue(32'h0000_0200, 1'b1, 32'h0000_0100,
              {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0}, -1, 2'd0, -1, 1'b1);
        issue(32'h0000_4000, 1'b0, 32'h0, '0, 0, 2'd2, 0, 1'b1);
        issue(32'h0000_5000, 1'b0, 32'h0, '0, 2, 2'd1, 1, 1'b1);
        issue(32'h0000_6004, 1'b1, 32'h0000_7000, {4{32'h1234_5678}}, 1, 2'd1, 0, 1'b1);
        issue(32'h0000_8000, 1'b1, 32'h0000_9000, {4{32'h0BAD_F00D}}, 3, 2'd2, -1, 1'b1);

        // Randomized requests.
        for (int t = 0; t < 40; t++) begin
            wb = 1'($urandom);
            for (int i = 0; i < int'(LINE_WORDS); i++) wd[i*WORD_W +: WORD_W] = $urandom;
            total = (wb ? int'(LINE_WORDS) : 0) + int'(LINE_WORDS);
            r = int'($urandom_range(0, 9));
            if (r < 7)      issue($urandom, wb, $urandom, wd, -1, 2'd0, -1, 1'b1);
            else if (r < 9) issue($urandom, wb, $urandom, wd, int'($urandom_range(0, total - 1)), 2'd1, -1, 1'b1);
            else            issue($urandom, wb, $urandom, wd, int'($urandom_range(0, total - 1)), 2'd2, -1, 1'b1);
        end

        // Reset while the second refill word is pending.
        issue(32'h0000_3004, 1'b0, 32'h0, '0, 1, 2'd3, 1, 1'b0);
        n = 0;
        while (exp_op_q.size() != 0 && n < 100) begin @(posedge clk_l2); #1; n++; end
        chk("rst_test_reached_word1", (LINE_W+1)'(exp_op_q.size()), '0);
        rst = 1'b1;
        @(posedge clk_l2); #1;
        chk("midrst_hsel", (LINE_W+1)'(bus.mem_hsel), '0);
        chk("midrst_req_ready", (LINE_W+1)'(bus.req_ready), (LINE_W+1)'(1));
        rst = 1'b0;
        repeat (3) @(posedge clk_l2);
        #1;
        issue(32'h0000_A00C, 1'b1, 32'h0000_B000, {4{32'hCAFE_0001}}, -1, 2'd0, -1, 1'b1);
        wait_ready();
        repeat (5) @(posedge clk_l2);
        #1;
        chk("ops_drained", (LINE_W+1)'(exp_op_q.size()), '0);
        chk("resps_drained", (LINE_W+1)'(exp_resp_q.size()), '0);
        chk("plan_drained", (LINE_W+1)'(plan_q.size()), '0);
        summary();
        $finish;
    end
endmodule
